// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract sequencer: loads the operand shift registers, consumes
// WIDTH LSB-first bit pairs through a full adder, then pulses done with the result.
module serial_addsub_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic             a_s,
  input  logic             b_s,
  output logic             load,
  output logic             shift,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  //  state    | meaning
  //  ST_IDLE  | waiting for start
  //  ST_LOAD  | parallel-load strobe to the operand shift registers
  //  ST_SHIFT | one operand bit pair consumed per cycle, WIDTH cycles
  //  ST_DONE  | result/cout/ovf valid, single-cycle pulse
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_DONE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic             sub_l;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic b_eff;
  logic sum_bit;
  logic carry_nxt;
  logic last_bit;

  // Subtraction inverts B here; the +1 comes from presetting carry in ST_LOAD.
  assign b_eff     = b_s ^ sub_l;
  assign sum_bit   = a_s ^ b_eff ^ carry;
  assign carry_nxt = (a_s & b_eff) | (a_s & carry) | (b_eff & carry);
  assign last_bit  = (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_LOAD;
      ST_LOAD:  state_nxt = ST_SHIFT;
      ST_SHIFT: if (last_bit) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Strobes are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load  <= 1'b0;
      shift <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      load  <= (state_nxt == ST_LOAD);
      shift <= (state_nxt == ST_SHIFT);
      busy  <= (state_nxt == ST_LOAD) || (state_nxt == ST_SHIFT);
      done  <= (state_nxt == ST_DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_l  <= 1'b0;
      carry  <= 1'b0;
      cnt    <= '0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) sub_l <= sub;
        end
        ST_LOAD: begin
          carry  <= sub_l;
          cnt    <= '0;
          result <= '0;
          cout   <= 1'b0;
          ovf    <= 1'b0;
        end
        ST_SHIFT: begin
          result <= {sum_bit, result[WIDTH-1:1]};
          carry  <= carry_nxt;
          cnt    <= cnt + CNT_W'(1);
          if (last_bit) begin
            cout <= carry_nxt;
            ovf  <= carry ^ carry_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
